// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction width, NOP encoding, instruction-memory
// FSM states and the major opcodes used by the core and its benches.
package mips_pkg;

    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } imem_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;

endpackage

// File: rtl/imem_array.sv
// DEPTH_WORDS x 32 instruction storage: one write port that drops out-of-range
// indices, one registered read port that holds its output when not enabled.
module imem_array
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6,
    parameter int WIDX_W      = 30
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [WIDX_W-1:0] wr_idx,
    input  logic [INST_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [INST_W-1:0] rd_data
);

    localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);

    logic [INST_W-1:0] mem [DEPTH_WORDS];

    // No reset: program contents survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_idx < DEPTH_LIM)) begin
            mem[wr_idx[IDX_W-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/imem_sync.sv
// Synchronous-read instruction memory with a one-outstanding fetch handshake,
// run-time program load port and misalign / out-of-range fault flags.
module imem_sync
    import mips_pkg::*;
#(
    parameter int               DEPTH_WORDS = 64,
    parameter int               ADDR_W      = 32,
    parameter logic [31:0]      NOP_WORD    = mips_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [INST_W-1:0] rsp_inst,
    output logic [ADDR_W-1:0] rsp_pc,
    output logic              rsp_misalign,
    output logic              rsp_oor,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [INST_W-1:0] prog_data,
    output imem_state_e       dbg_state
);

    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never depends on ready, and the rsp_* payload stays
    // frozen while rsp_valid is high and rsp_ready is low.

    imem_state_e       state, state_nxt;
    logic [WIDX_W-1:0] req_idx;
    logic              req_misalign, req_oor, req_fault, accept;
    logic              nop_q;
    logic [INST_W-1:0] arr_rdata;
    logic              prog_addr_unused;

    assign req_idx      = req_pc[ADDR_W-1:2];
    assign req_misalign = |req_pc[1:0];
    assign req_oor      = (req_idx >= DEPTH_LIM);
    assign req_fault    = req_misalign | req_oor;
    assign accept       = req_valid & req_ready;
    assign prog_addr_unused = ^prog_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~prog_we;
                if (accept) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready & ~prog_we;
                if (rsp_ready && !accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response side-band registers load only on accept, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pc       <= '0;
            rsp_misalign <= 1'b0;
            rsp_oor      <= 1'b0;
            nop_q        <= 1'b1;
        end else if (accept) begin
            rsp_pc       <= req_pc;
            rsp_misalign <= req_misalign;
            rsp_oor      <= req_oor;
            nop_q        <= req_fault;
        end
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .WIDX_W      (WIDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (prog_we),
        .wr_idx  (prog_addr[ADDR_W-1:2]),
        .wr_data (prog_data),
        .rd_en   (accept & ~req_fault),
        .rd_idx  (req_idx[IDX_W-1:0]),
        .rd_data (arr_rdata)
    );

    // Faulted fetches never read the array; the NOP is substituted on the way out.
    assign rsp_inst  = nop_q ? NOP_WORD : arr_rdata;
    assign dbg_state = state;

endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the MIPS core; replaces the combinational byte-array ROM.
- Stores big-endian 32-bit instructions at byte addresses, word-aligned.
- Fetch is a request/response handshake with one outstanding access and backpressure.
- A program-load write port fills memory at run time; the fetch stage gets fault flags for misaligned and out-of-range PCs.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit instruction words stored.
- ADDR_W, 32, width of byte address (PC).
- NOP_WORD, 32'h0000_0000, instruction returned on any faulted fetch.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_pc  in  ADDR_W  byte address of the instruction to fetch.
- rsp_valid  out  1  response word available.
- rsp_ready  in  1  fetch stage accepts the response.
- rsp_inst  out  32  instruction word; byte at PC is bits [31:24].
- rsp_pc  out  ADDR_W  PC of the returned instruction.
- rsp_misalign  out  1  req_pc[1:0] != 0.
- rsp_oor  out  1  word index >= DEPTH_WORDS.
- prog_we  in  1  program-load word write.
- prog_addr  in  ADDR_W  byte address of the load word (low 2 bits ignored).
- prog_data  in  32  word to write, big-endian.

Behaviour:
- Reset values: rsp_valid=0, rsp_inst=NOP_WORD, rsp_pc=0, rsp_misalign=0, rsp_oor=0, FSM=IDLE.
- Reset does not clear the memory array. Reset mid-transaction drops any pending response.
- FSM has two states:
  - IDLE: req_ready=1 unless prog_we=1. On accept (req_valid & req_ready) go to RESP.
  - RESP: rsp_valid=1. req_ready = rsp_ready & ~prog_we, which gives back-to-back throughput.
    - On rsp_ready with no new accept, go to IDLE.
    - On rsp_ready with a new accept, stay in RESP and load the next response.
    - Without rsp_ready, hold rsp_* stable.
- Latency: request accepted in cycle N; response is valid in cycle N+1 and stays valid until accepted.
- Word index = req_pc[ADDR_W-1:2], width clog2(DEPTH_WORDS).
- Index compare uses the full upper PC bits, so any set bit at or above the index width gives rsp_oor=1.
- Fault handling:
  - misalign or oor: rsp_inst=NOP_WORD, the array is not read, and the flags register with the response.
  - Both faults can assert together.
- Program load:
  - prog_we writes the word at prog_addr[..:2] on the clock edge.
  - A write to an out-of-range index is silently dropped.
  - While prog_we=1, req_ready=0, so load has priority and no fetch is accepted that cycle.
  - A response already held in RESP is unaffected even if its word is overwritten (data was captured at accept).
- No write-read bypass is needed, because a fetch cannot be accepted in the same cycle as a load.

Decomposition:
- Shared package mips_pkg holds:
  - INST_W=32.
  - NOP_WORD constant.
  - imem state enum {IDLE, RESP}.
  - Opcode constants reused by the bench (LW=6'h23, SW=6'h2B, ANDI=6'h0C, R-type=6'h00).
- One sub-module, imem_array: a DEPTH_WORDS x 32 single-port-write, registered-read array with an out-of-range write guard.
- The FSM, fault logic and response registers stay in imem_sync.

Test Plan:
- Load and fetch: load words 0x8C41000A@0, 0xAC610005@4, 0x00A31025@8, then reset, then fetch PCs 0,4,8 back-to-back with rsp_ready=1.
  - Required: rsp_inst in that order, one per cycle, starting the cycle after the first accept; flags 0.
- Backpressure: fetch PC 4 with rsp_ready=0 for 3 cycles.
  - Required: rsp_valid=1, rsp_inst=0xAC610005 and rsp_pc=4 held stable; req_ready=0.
  - After rsp_ready=1, the next request is accepted in the same cycle.
- Faults:
  - Fetch PC 6: rsp_misalign=1, rsp_inst=0.
  - Fetch PC 4*DEPTH_WORDS: rsp_oor=1, rsp_inst=0.
  - Fetch PC 0xFFFF_FFFE: both flags set.
- Load priority: prog_we=1 with req_valid=1.
  - Required: req_ready=0 and no response issued.
  - Next cycle a fetch of the written address returns the new word (0x3061000A).
- Reset mid-RESP (rsp_ready=0) → next cycle rsp_valid=0, FSM IDLE; memory contents are preserved (refetch PC 0 returns 0x8C41000A).
- Out-of-range load write to index DEPTH_WORDS → no in-range word is changed (verify words 0..DEPTH_WORDS-1 unchanged).
